// File: rtl/jgate_pipe_if.sv
// Operand/result handshake bundle for jgate_pipe.
// The master side presents operands and consumes results; the slave side is the pipe.
interface jgate_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/jgate_pipe.sv
// jgate_pipe: single-stage registered logic-gate unit with valid/ready handshake
// and a saturating count of accepted operand sets.
module jgate_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  jgate_pipe_if.slave      bus,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] y_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic             accept;
  logic [WIDTH-1:0] and_v, or_v, xor_v;
  logic [WIDTH-1:0] result_next;

  // Ready is forced high during reset so upstream never sees a stale stall;
  // the accept itself is masked by rst so nothing is captured.
  assign bus.in_ready = rst || (state_reg == EMPTY) || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready && !rst;

  // Per-bit primitive gates shared by the bitwise and reduction operations.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign and_v[gi] = bus.a[gi] & bus.b[gi];
      assign or_v[gi]  = bus.a[gi] | bus.b[gi];
      assign xor_v[gi] = bus.a[gi] ^ bus.b[gi];
    end
  endgenerate

  // Select the operation result that will be captured on accept.
  always_comb begin
    result_next = '0;
    case (bus.op)
      3'b000: result_next = and_v;
      3'b001: result_next = or_v;
      3'b010: result_next = xor_v;
      3'b011: result_next = ~and_v;
      3'b100: result_next = ~or_v;
      3'b101: result_next = ~xor_v;
      3'b110: result_next[0] = &and_v;
      3'b111: result_next[0] = ^xor_v;
      default: result_next = '0;
    endcase
  end

  // Output stage FSM: state, registered result, valid flag and saturating counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= EMPTY;
      out_valid_reg <= 1'b0;
      y_reg         <= '0;
      cnt_reg       <= '0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            state_reg     <= FULL;
            out_valid_reg <= 1'b1;
            y_reg         <= result_next;
          end
        end
        FULL: begin
          if (bus.out_ready) begin
            if (accept) begin
              y_reg <= result_next;
            end else begin
              state_reg     <= EMPTY;
              out_valid_reg <= 1'b0;
            end
          end
        end
        default: begin
          state_reg     <= EMPTY;
          out_valid_reg <= 1'b0;
        end
      endcase
      if (accept && (cnt_reg != {CNT_W{1'b1}})) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.y         = y_reg;
  assign op_count      = cnt_reg;

endmodule

// File: tb/tb_jgate_pipe.sv
// Testbench for jgate_pipe: directed scenarios plus randomized traffic, checked by a
// queue-based scoreboard fed from a behavioural model of the gate operations.
module tb_jgate_pipe;

  localparam int WIDTH  = 8;
  localparam int CNT_W  = 16;
  localparam int CNT_W2 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jgate_pipe_if #(.WIDTH(WIDTH)) bus ();
  jgate_pipe_if #(.WIDTH(WIDTH)) bus2 ();
  logic [CNT_W-1:0]  op_count;
  logic [CNT_W2-1:0] op_count2;

  // Second instance sees identical stimulus; only its counter width differs.
  assign bus2.in_valid  = bus.in_valid;
  assign bus2.a         = bus.a;
  assign bus2.b         = bus.b;
  assign bus2.op        = bus.op;
  assign bus2.out_ready = bus.out_ready;

  jgate_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .op_count(op_count)
  );
  jgate_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .op_count(op_count2)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference semantics of each op code, written directly from the operation table.
  function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] o,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] z);
    case (o)
      3'd0: return x & z;
      3'd1: return x | z;
      3'd2: return x ^ z;
      3'd3: return ~(x & z);
      3'd4: return ~(x | z);
      3'd5: return ~(x ^ z);
      3'd6: return ((x & z) == {WIDTH{1'b1}}) ? 1 : 0;
      default: return ($countones(x ^ z) % 2 == 1) ? 1 : 0;
    endcase
  endfunction

  // Scoreboard state: pending results, last delivered value and expected counts.
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] last_y = '0;
  longint           cnt_m  = 0;
  longint           cnt_m2 = 0;
  bit               started = 0;

  // Model: on each rising edge decide whether an accept occurs and push its result.
  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      exp_q.delete();
      last_y = '0;
      cnt_m  = 0;
      cnt_m2 = 0;
    end else if (bus.in_valid && exp_q.size() == 0) begin
      logic [WIDTH-1:0] r;
      r = ref_op(bus.op, bus.a, bus.b);
      exp_q.push_back(r);
      last_y = r;
      if (cnt_m < (2 ** CNT_W) - 1) cnt_m++;
      if (cnt_m2 < (2 ** CNT_W2) - 1) cnt_m2++;
      $display("[TB] accept op=%0d a=0x%02h b=0x%02h -> expect 0x%02h count=%0d",
               bus.op, bus.a, bus.b, r, cnt_m);
    end
  end

  // Monitor: mid-cycle compare of outputs against the scoreboard, then pop on consume.
  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", {31'd0, bus.in_ready},
          {31'd0, (rst || exp_q.size() == 0 || bus.out_ready)});
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_q.size() != 0});
      chk("y", {24'd0, bus.y}, {24'd0, (exp_q.size() != 0) ? exp_q[0] : last_y});
      chk("op_count", {16'd0, op_count}, cnt_m[31:0]);
      chk("op_count_w2", {30'd0, op_count2}, cnt_m2[31:0]);
      if (exp_q.size() != 0 && bus.out_ready && !rst) begin
        $display("[TB] consume y=0x%02h", bus.y);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] aa, input logic [7:0] bb,
                       input logic [2:0] oo, input logic ordy);
    bus.in_valid  = v;
    bus.a         = aa;
    bus.b         = bb;
    bus.op        = oo;
    bus.out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [7:0] stream_exp [8] = '{8'h81, 8'h81, 8'h00, 8'h7E, 8'h7E, 8'hFF, 8'h00, 8'h00};
  logic [1:0] sat_exp    [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    rst = 1'b1;
    tick();
    tick();
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    rst = 1'b0;
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_y", {24'd0, bus.y}, 32'd0);
    chk("reset_count", {16'd0, op_count}, 32'd0);

    // Single AND transaction with one-cycle result lifetime.
    drive(1'b1, 8'hF0, 8'h3C, 3'd0, 1'b1);
    tick();
    chk("and_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("and_y", {24'd0, bus.y}, 32'h30);
    chk("and_count", {16'd0, op_count}, 32'd1);
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    tick();
    chk("and_drop", {31'd0, bus.out_valid}, 32'd0);

    // Backpressure: result held while out_ready is low.
    do_reset();
    drive(1'b1, 8'h0F, 8'hA0, 3'd1, 1'b0);
    tick();
    chk("bp_y", {24'd0, bus.y}, 32'hAF);
    chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
    drive(1'b1, 8'hFF, 8'h0F, 3'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_stall_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_hold_y", {24'd0, bus.y}, 32'hAF);
      chk("bp_hold_count", {16'd0, op_count}, 32'd1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    chk("bp_next_y", {24'd0, bus.y}, 32'hF0);
    chk("bp_next_count", {16'd0, op_count}, 32'd2);

    // Streaming all eight ops back to back; also exercises 2-bit counter saturation.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'h81, 8'h81, 3'(i), 1'b1);
      tick();
      chk("stream_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("stream_y", {24'd0, bus.y}, {24'd0, stream_exp[i]});
      if (i < 5) chk("sat_count_w2", {30'd0, op_count2}, {30'd0, sat_exp[i]});
    end
    chk("stream_count", {16'd0, op_count}, 32'd8);

    // Reduction corner cases.
    drive(1'b1, 8'hFF, 8'hFF, 3'd6, 1'b1);
    tick();
    chk("and_reduce", {24'd0, bus.y}, 32'h01);
    drive(1'b1, 8'h07, 8'h00, 3'd7, 1'b1);
    tick();
    chk("parity", {24'd0, bus.y}, 32'h01);

    // Reset while FULL and stalled, with a simultaneous accept attempt.
    drive(1'b1, 8'h12, 8'h34, 3'd1, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    chk("rst_ready_during", {31'd0, bus.in_ready}, 32'd1);
    tick();
    rst = 1'b0;
    chk("rst_full_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_full_y", {24'd0, bus.y}, 32'd0);
    chk("rst_full_count", {16'd0, op_count}, 32'd0);
    chk("rst_full_ready", {31'd0, bus.in_ready}, 32'd1);
    drive(1'b1, 8'hCC, 8'hAA, 3'd2, 1'b1);
    tick();
    chk("post_rst_y", {24'd0, bus.y}, 32'h66);
    chk("post_rst_count", {16'd0, op_count}, 32'd1);

    // Randomized traffic checked by the scoreboard.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom),
            3'($urandom_range(0, 7)), ($urandom_range(0, 9) < 6));
      rst = ($urandom_range(0, 99) < 2);
      tick();
    end
    rst = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
